// File: rtl/noc_traffic_node_if.sv
// Flit channels of one traffic node: the outbound sender link and the inbound receive link.
// The master modport is the node's view; the slave modport is the router/environment view.
interface noc_traffic_node_if #(
    parameter int DATA_W = 64
);
    logic              receive_valid;
    logic              receive_ready;
    logic [DATA_W-1:0] receive_flit;
    logic              receive_is_header;
    logic              receive_is_tail;
    logic              sender_valid;
    logic              sender_ready;
    logic [DATA_W-1:0] sender_flit;
    logic              sender_is_header;
    logic              sender_is_tail;

    modport master (
        input  receive_valid, receive_flit, receive_is_header, receive_is_tail, sender_ready,
        output receive_ready, sender_valid, sender_flit, sender_is_header, sender_is_tail
    );

    modport slave (
        output receive_valid, receive_flit, receive_is_header, receive_is_tail, sender_ready,
        input  receive_ready, sender_valid, sender_flit, sender_is_header, sender_is_tail
    );
endinterface

// File: rtl/noc_traffic_node.sv
// NoC traffic node: generates bursts of head/data/tail packets and checks inbound packets
// addressed to this node, keeping saturating sent/received/error counters.
module noc_traffic_node #(
    parameter int          DATA_W      = 64,
    parameter int          ID_X_W      = 4,
    parameter int          ID_Y_W      = 4,
    parameter int          X_ID        = 0,
    parameter int          Y_ID        = 0,
    parameter int          PAYLOAD_LEN = 2,
    parameter int          NUM_PKTS    = 4,
    parameter int          DEST_MODE   = 0,
    parameter int          DEST_X_ID   = 1,
    parameter int          DEST_Y_ID   = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                noc_clk,
    input  logic                noc_rst_n,
    input  logic                send_start,
    noc_traffic_node_if.master  link,
    output logic                tx_busy,
    output logic [15:0]         tx_pkt_cnt,
    output logic [15:0]         rx_pkt_cnt,
    output logic [15:0]         rx_err_cnt
);
    localparam int IDW = ID_X_W + ID_Y_W;
    localparam int HW  = 2 * IDW + 20;
    localparam int DW  = IDW + 12;
    localparam logic [ID_X_W-1:0] MY_X     = ID_X_W'(X_ID);
    localparam logic [ID_Y_W-1:0] MY_Y     = ID_Y_W'(Y_ID);
    localparam logic [ID_X_W-1:0] FIX_X    = ID_X_W'(DEST_X_ID);
    localparam logic [ID_Y_W-1:0] FIX_Y    = ID_Y_W'(DEST_Y_ID);
    localparam logic [3:0]        LEN      = 4'(PAYLOAD_LEN);
    localparam logic [3:0]        LAST_K   = 4'(PAYLOAD_LEN - 1);
    localparam logic [15:0]       LAST_PKT = 16'(NUM_PKTS - 1);

    typedef enum logic [1:0] {IDLE, HEAD, DATA, TAIL} tx_state_e;
    typedef enum logic [1:0] {R_HEAD, R_DATA, R_TAIL} rx_state_e;

    function automatic logic [DATA_W-1:0] ctrl_flit(input logic [7:0] mk,
            input logic [ID_X_W-1:0] sx, input logic [ID_Y_W-1:0] sy,
            input logic [ID_X_W-1:0] dx, input logic [ID_Y_W-1:0] dy, input logic [7:0] sq);
        logic [DATA_W-1:0] f;
        f = '0;
        f[DATA_W-1 -: HW] = {mk, sx, sy, dx, dy, LEN, sq};
        return f;
    endfunction

    function automatic logic [DATA_W-1:0] data_flit(input logic [ID_X_W-1:0] sx,
            input logic [ID_Y_W-1:0] sy, input logic [7:0] sq, input logic [3:0] k);
        logic [DATA_W-1:0] f;
        f = '0;
        f[DW-1:0] = {sx, sy, sq, k};
        return f;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, v} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    tx_state_e tx_state_q, tx_state_d;
    logic [7:0]        seq_q, seq_d;
    logic [3:0]        k_q, k_d;
    logic [15:0]       burst_q, burst_d;
    logic [15:0]       lfsr_q, lfsr_d, lfsr_adv;
    logic [ID_X_W-1:0] dst_x_q, dst_x_d, rnd_x;
    logic [ID_Y_W-1:0] dst_y_q, dst_y_d, rnd_y;
    logic [15:0]       tx_pkt_cnt_q, tx_pkt_cnt_d;
    logic              sender_valid_q, sender_valid_d, hdr_q, hdr_d, tail_q, tail_d;
    logic [DATA_W-1:0] sender_flit_q, sender_flit_d;
    logic              tx_busy_q, tx_busy_d, tx_fire, enter_head;

    rx_state_e rx_state_q, rx_state_d;
    logic [ID_X_W-1:0] src_x_q, src_x_d, h_sx, h_dx;
    logic [ID_Y_W-1:0] src_y_q, src_y_d, h_sy, h_dy;
    logic [7:0]        rseq_q, rseq_d, h_mk, h_sq;
    logic [3:0]        rk_q, rk_d, h_len;
    logic [15:0]       rx_pkt_cnt_q, rx_pkt_cnt_d, rx_err_cnt_q, rx_err_cnt_d;
    logic              receive_ready_q, receive_ready_d;
    logic              rx_acc, head_ok, data_ok, tail_ok, take_head, pkt_inc;
    logic [1:0]        err_inc;

    assign tx_fire  = sender_valid_q & link.sender_ready;
    assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign {rnd_x, rnd_y} = lfsr_adv[IDW-1:0];

    // Transmit sequencing: next state, packet bookkeeping and next registered flit outputs.
    always_comb begin
        tx_state_d   = tx_state_q;
        seq_d        = seq_q;
        k_d          = k_q;
        burst_d      = burst_q;
        lfsr_d       = lfsr_q;
        dst_x_d      = dst_x_q;
        dst_y_d      = dst_y_q;
        tx_pkt_cnt_d = tx_pkt_cnt_q;
        enter_head   = 1'b0;
        case (tx_state_q)
            IDLE: begin
                if (send_start) begin
                    tx_state_d = HEAD;
                    burst_d    = 16'd0;
                    enter_head = 1'b1;
                end else begin
                    tx_state_d = IDLE;
                end
            end
            HEAD: begin
                if (tx_fire) begin
                    tx_state_d = DATA;
                    k_d        = 4'd0;
                end else begin
                    tx_state_d = HEAD;
                end
            end
            DATA: begin
                if (tx_fire && (k_q == LAST_K)) begin
                    tx_state_d = TAIL;
                end else if (tx_fire) begin
                    k_d = k_q + 4'd1;
                end else begin
                    tx_state_d = DATA;
                end
            end
            TAIL: begin
                if (tx_fire) begin
                    seq_d        = seq_q + 8'd1;
                    tx_pkt_cnt_d = sat_add(tx_pkt_cnt_q, 2'd1);
                    burst_d      = burst_q + 16'd1;
                    if ((NUM_PKTS != 0) && (burst_q == LAST_PKT)) begin
                        tx_state_d = IDLE;
                    end else begin
                        tx_state_d = HEAD;
                        enter_head = 1'b1;
                    end
                end else begin
                    tx_state_d = TAIL;
                end
            end
            default: tx_state_d = IDLE;
        endcase
        // A random destination equal to our own ID is nudged along X so we never address ourselves.
        if (enter_head && (DEST_MODE == 1)) begin
            lfsr_d  = lfsr_adv;
            dst_y_d = rnd_y;
            if ({rnd_x, rnd_y} == {MY_X, MY_Y}) begin
                dst_x_d = rnd_x + ID_X_W'(1);
            end else begin
                dst_x_d = rnd_x;
            end
        end else if (enter_head) begin
            dst_x_d = FIX_X;
            dst_y_d = FIX_Y;
        end else begin
            lfsr_d = lfsr_q;
        end
        sender_valid_d = (tx_state_d != IDLE);
        tx_busy_d      = (tx_state_d != IDLE);
        hdr_d          = (tx_state_d == HEAD);
        tail_d         = (tx_state_d == TAIL);
        case (tx_state_d)
            HEAD:    sender_flit_d = ctrl_flit(8'hA5, MY_X, MY_Y, dst_x_d, dst_y_d, seq_d);
            DATA:    sender_flit_d = data_flit(MY_X, MY_Y, seq_d, k_d);
            TAIL:    sender_flit_d = ctrl_flit(8'h5A, MY_X, MY_Y, dst_x_d, dst_y_d, seq_d);
            default: sender_flit_d = '0;
        endcase
    end

    assign rx_acc = link.receive_valid & receive_ready_q;
    assign {h_mk, h_sx, h_sy, h_dx, h_dy, h_len, h_sq} = link.receive_flit[DATA_W-1 -: HW];
    assign head_ok = link.receive_is_header && (h_mk == 8'hA5) && (h_dx == MY_X)
                     && (h_dy == MY_Y) && (h_len == LEN);
    assign data_ok = (link.receive_flit == data_flit(src_x_q, src_y_q, rseq_q, rk_q));
    assign tail_ok = link.receive_is_tail && (link.receive_flit[DATA_W-1 -: HW] ==
                     {8'h5A, src_x_q, src_y_q, MY_X, MY_Y, LEN, rseq_q});

    // Receive checking: a stray header both closes the broken packet and opens a new one.
    always_comb begin
        rx_state_d      = rx_state_q;
        src_x_d         = src_x_q;
        src_y_d         = src_y_q;
        rseq_d          = rseq_q;
        rk_d            = rk_q;
        err_inc         = 2'd0;
        pkt_inc         = 1'b0;
        take_head       = 1'b0;
        receive_ready_d = 1'b1;
        if (rx_acc) begin
            case (rx_state_q)
                R_HEAD: take_head = 1'b1;
                R_DATA: begin
                    if (link.receive_is_header) begin
                        err_inc   = 2'd1;
                        take_head = 1'b1;
                    end else if (data_ok && (rk_q == LAST_K)) begin
                        rx_state_d = R_TAIL;
                    end else if (data_ok) begin
                        rk_d = rk_q + 4'd1;
                    end else begin
                        err_inc    = 2'd1;
                        rx_state_d = R_HEAD;
                    end
                end
                R_TAIL: begin
                    if (link.receive_is_header) begin
                        err_inc   = 2'd1;
                        take_head = 1'b1;
                    end else if (tail_ok) begin
                        pkt_inc    = 1'b1;
                        rx_state_d = R_HEAD;
                    end else begin
                        err_inc    = 2'd1;
                        rx_state_d = R_HEAD;
                    end
                end
                default: rx_state_d = R_HEAD;
            endcase
        end else begin
            rx_state_d = rx_state_q;
        end
        if (take_head && head_ok) begin
            rx_state_d = R_DATA;
            src_x_d    = h_sx;
            src_y_d    = h_sy;
            rseq_d     = h_sq;
            rk_d       = 4'd0;
        end else if (take_head) begin
            err_inc    = err_inc + 2'd1;
            rx_state_d = R_HEAD;
        end else begin
            rk_d = rk_d;
        end
        rx_pkt_cnt_d = sat_add(rx_pkt_cnt_q, {1'b0, pkt_inc});
        rx_err_cnt_d = sat_add(rx_err_cnt_q, err_inc);
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            tx_state_q      <= IDLE;
            seq_q           <= 8'd0;
            k_q             <= 4'd0;
            burst_q         <= 16'd0;
            lfsr_q          <= LFSR_SEED;
            dst_x_q         <= FIX_X;
            dst_y_q         <= FIX_Y;
            tx_pkt_cnt_q    <= 16'd0;
            sender_valid_q  <= 1'b0;
            sender_flit_q   <= '0;
            hdr_q           <= 1'b0;
            tail_q          <= 1'b0;
            tx_busy_q       <= 1'b0;
            rx_state_q      <= R_HEAD;
            src_x_q         <= '0;
            src_y_q         <= '0;
            rseq_q          <= 8'd0;
            rk_q            <= 4'd0;
            rx_pkt_cnt_q    <= 16'd0;
            rx_err_cnt_q    <= 16'd0;
            receive_ready_q <= 1'b0;
        end else begin
            tx_state_q      <= tx_state_d;
            seq_q           <= seq_d;
            k_q             <= k_d;
            burst_q         <= burst_d;
            lfsr_q          <= lfsr_d;
            dst_x_q         <= dst_x_d;
            dst_y_q         <= dst_y_d;
            tx_pkt_cnt_q    <= tx_pkt_cnt_d;
            sender_valid_q  <= sender_valid_d;
            sender_flit_q   <= sender_flit_d;
            hdr_q           <= hdr_d;
            tail_q          <= tail_d;
            tx_busy_q       <= tx_busy_d;
            rx_state_q      <= rx_state_d;
            src_x_q         <= src_x_d;
            src_y_q         <= src_y_d;
            rseq_q          <= rseq_d;
            rk_q            <= rk_d;
            rx_pkt_cnt_q    <= rx_pkt_cnt_d;
            rx_err_cnt_q    <= rx_err_cnt_d;
            receive_ready_q <= receive_ready_d;
        end
    end

`ifndef SYNTHESIS
    // Simulation trace: one line per packet sent and per good packet received.
    always_ff @(posedge noc_clk) begin
        if (noc_rst_n && tx_fire && (tx_state_q == TAIL)) begin
            $display("noc_traffic_node(%0d,%0d) sent: src=(%0d,%0d) dst=(%0d,%0d) seq=%0d",
                     X_ID, Y_ID, MY_X, MY_Y, dst_x_q, dst_y_q, seq_q);
        end
        if (noc_rst_n && pkt_inc) begin
            $display("noc_traffic_node(%0d,%0d) received: src=(%0d,%0d) dst=(%0d,%0d) seq=%0d",
                     X_ID, Y_ID, src_x_q, src_y_q, MY_X, MY_Y, rseq_q);
        end
    end
`endif

    assign link.sender_valid     = sender_valid_q;
    assign link.sender_flit      = sender_flit_q;
    assign link.sender_is_header = hdr_q;
    assign link.sender_is_tail   = tail_q;
    assign link.receive_ready    = receive_ready_q;
    assign tx_busy               = tx_busy_q;
    assign tx_pkt_cnt            = tx_pkt_cnt_q;
    assign rx_pkt_cnt            = rx_pkt_cnt_q;
    assign rx_err_cnt            = rx_err_cnt_q;
endmodule

// File: tb/tb_noc_traffic_node.sv
// Directed bench for noc_traffic_node: burst format, backpressure, loopback, RX error
// handling, random destinations and mid-packet reset, with hand-built expected flits.
module tb_noc_traffic_node;
    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_b, start_c, rdy_a;
    logic        busy_a, busy_b, busy_c;
    logic [15:0] txc_a, rxc_a, erc_a, txc_b, rxc_b, erc_b, txc_c, rxc_c, erc_c;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    noc_traffic_node_if #(.DATA_W(64)) if_a ();
    noc_traffic_node_if #(.DATA_W(64)) if_b ();
    noc_traffic_node_if #(.DATA_W(64)) if_c ();

    assign if_a.sender_ready = rdy_a;

    assign if_b.sender_ready      = 1'b1;
    assign if_b.receive_valid     = if_b.sender_valid;
    assign if_b.receive_flit      = if_b.sender_flit;
    assign if_b.receive_is_header = if_b.sender_is_header;
    assign if_b.receive_is_tail   = if_b.sender_is_tail;

    assign if_c.sender_ready      = 1'b1;
    assign if_c.receive_valid     = 1'b0;
    assign if_c.receive_flit      = 64'd0;
    assign if_c.receive_is_header = 1'b0;
    assign if_c.receive_is_tail   = 1'b0;

    noc_traffic_node u_a (
        .noc_clk(clk), .noc_rst_n(rst_n), .send_start(start_a), .link(if_a.master),
        .tx_busy(busy_a), .tx_pkt_cnt(txc_a), .rx_pkt_cnt(rxc_a), .rx_err_cnt(erc_a)
    );

    noc_traffic_node #(.X_ID(1), .DEST_X_ID(1)) u_b (
        .noc_clk(clk), .noc_rst_n(rst_n), .send_start(start_b), .link(if_b.master),
        .tx_busy(busy_b), .tx_pkt_cnt(txc_b), .rx_pkt_cnt(rxc_b), .rx_err_cnt(erc_b)
    );

    noc_traffic_node #(.DEST_MODE(1), .NUM_PKTS(0)) u_c (
        .noc_clk(clk), .noc_rst_n(rst_n), .send_start(start_c), .link(if_c.master),
        .tx_busy(busy_c), .tx_pkt_cnt(txc_c), .rx_pkt_cnt(rxc_c), .rx_err_cnt(erc_c)
    );

    function automatic logic [63:0] ctrl(input logic [7:0] mk, input logic [3:0] sx,
            input logic [3:0] sy, input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] sq);
        return {mk, sx, sy, dx, dy, 4'd2, sq, 28'd0};
    endfunction

    function automatic logic [63:0] dflit(input logic [3:0] sx, input logic [3:0] sy,
            input logic [7:0] sq, input logic [3:0] k);
        return {44'd0, sx, sy, sq, k};
    endfunction

    // Flit j (0 head, 1..2 data, 3 tail) of packet seq p sent by u_a: src (0,0), dst (1,0).
    function automatic logic [63:0] exp_tx(input int p, input int j);
        logic [7:0] sq;
        sq = 8'(p);
        if (j == 0) return ctrl(8'hA5, 4'd0, 4'd0, 4'd1, 4'd0, sq);
        else if (j == 3) return ctrl(8'h5A, 4'd0, 4'd0, 4'd1, 4'd0, sq);
        else return dflit(4'd0, 4'd0, sq, 4'(j - 1));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx(input logic [63:0] f, input logic h, input logic t);
        if_a.receive_flit      = f;
        if_a.receive_is_header = h;
        if_a.receive_is_tail   = t;
        if_a.receive_valid     = 1'b1;
        step();
        if_a.receive_valid     = 1'b0;
        if_a.receive_is_header = 1'b0;
        if_a.receive_is_tail   = 1'b0;
    endtask

    task automatic rx_pkt(input logic [7:0] sq);
        rx(ctrl(8'hA5, 4'd3, 4'd2, 4'd0, 4'd0, sq), 1'b1, 1'b0);
        rx(dflit(4'd3, 4'd2, sq, 4'd0), 1'b0, 1'b0);
        rx(dflit(4'd3, 4'd2, sq, 4'd1), 1'b0, 1'b0);
        rx(ctrl(8'h5A, 4'd3, 4'd2, 4'd0, 4'd0, sq), 1'b0, 1'b1);
    endtask

    initial begin
        int idx;
        int zero_seen;
        logic [15:0] l;
        logic [7:0]  d;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; rdy_a = 1'b1;
        if_a.receive_valid = 1'b0; if_a.receive_flit = 64'd0;
        if_a.receive_is_header = 1'b0; if_a.receive_is_tail = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", if_a.sender_valid, 1'b0);
        chk("rst_flit", if_a.sender_flit, 64'd0);
        chk("rst_flags", {if_a.sender_is_header, if_a.sender_is_tail}, 2'b00);
        chk("rst_ready", if_a.receive_ready, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_counts", {txc_a, rxc_a, erc_a}, 48'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", if_a.receive_ready, 1'b1);

        // Full-rate burst; send_start pulsed mid-burst must be ignored.
        start_a = 1'b1; start_b = 1'b1;
        step();
        start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("burst_flit", if_a.sender_flit, exp_tx(i / 4, i % 4));
            chk("burst_valid", if_a.sender_valid, 1'b1);
            chk("burst_hdr", if_a.sender_is_header, (i % 4) == 0);
            chk("burst_tail", if_a.sender_is_tail, (i % 4) == 3);
            chk("burst_busy", busy_a, 1'b1);
            if (i == 5) start_a = 1'b1;
            else if (i == 8) start_a = 1'b0;
            step();
        end
        chk("burst_end_valid", if_a.sender_valid, 1'b0);
        chk("burst_end_busy", busy_a, 1'b0);
        chk("burst_pkt_cnt", txc_a, 16'd4);
        chk("loop_tx_cnt", txc_b, 16'd4);
        chk("loop_rx_cnt", rxc_b, 16'd4);
        chk("loop_err_cnt", erc_b, 16'd0);

        // Backpressure: ready alternates, flits must hold until accepted.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 100 && idx < 16; cyc++) begin
            chk("bp_flit", if_a.sender_flit, exp_tx(4 + idx / 4, idx % 4));
            chk("bp_valid", if_a.sender_valid, 1'b1);
            chk("bp_flags", {if_a.sender_is_header, if_a.sender_is_tail},
                {(idx % 4) == 0, (idx % 4) == 3});
            if (rdy_a) idx++;
            step();
            rdy_a = ~rdy_a;
        end
        rdy_a = 1'b1;
        chk("bp_done", 64'(idx), 64'd16);
        chk("bp_end_valid", if_a.sender_valid, 1'b0);
        chk("bp_pkt_cnt", txc_a, 16'd8);

        // Receive side: corrupted data k, then a good packet.
        rx(ctrl(8'hA5, 4'd3, 4'd2, 4'd0, 4'd0, 8'd7), 1'b1, 1'b0);
        rx(dflit(4'd3, 4'd2, 8'd7, 4'd0), 1'b0, 1'b0);
        rx(dflit(4'd3, 4'd2, 8'd7, 4'd5), 1'b0, 1'b0);
        chk("badk_err", erc_a, 16'd1);
        chk("badk_pkt", rxc_a, 16'd0);
        rx_pkt(8'd8);
        chk("good_after_badk_pkt", rxc_a, 16'd1);
        chk("good_after_badk_err", erc_a, 16'd1);

        // Head arriving in place of the second data flit restarts as a new packet.
        rx(ctrl(8'hA5, 4'd3, 4'd2, 4'd0, 4'd0, 8'd9), 1'b1, 1'b0);
        rx(dflit(4'd3, 4'd2, 8'd9, 4'd0), 1'b0, 1'b0);
        rx_pkt(8'd10);
        chk("early_head_err", erc_a, 16'd2);
        chk("early_head_pkt", rxc_a, 16'd2);

        rx(ctrl(8'hA5, 4'd3, 4'd2, 4'd1, 4'd0, 8'd11), 1'b1, 1'b0);
        chk("wrong_dst_err", erc_a, 16'd3);
        rx(ctrl(8'hA5, 4'd3, 4'd2, 4'd0, 4'd0, 8'd11), 1'b0, 1'b0);
        chk("no_hdr_flag_err", erc_a, 16'd4);
        rx(ctrl(8'hA5, 4'd3, 4'd2, 4'd0, 4'd0, 8'd12), 1'b1, 1'b0);
        rx(dflit(4'd3, 4'd2, 8'd12, 4'd0), 1'b0, 1'b0);
        rx(dflit(4'd3, 4'd2, 8'd12, 4'd1), 1'b0, 1'b0);
        rx(ctrl(8'h5A, 4'd3, 4'd2, 4'd0, 4'd0, 8'd13), 1'b0, 1'b1);
        chk("tail_seq_err", erc_a, 16'd5);
        chk("tail_seq_pkt", rxc_a, 16'd2);
        rx_pkt(8'd14);
        chk("recover_pkt", rxc_a, 16'd3);

        // Random destinations over 1000 packets from own ID (0,0).
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        l = 16'hACE1;
        zero_seen = 0;
        for (int p = 0; p < 1000; p++) begin
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            d = l[7:0];
            if (d == 8'd0) d = 8'h10;
            chk("rnd_head", {if_c.sender_is_header, if_c.sender_flit},
                {1'b1, ctrl(8'hA5, 4'd0, 4'd0, d[7:4], d[3:0], 8'(p))});
            if (if_c.sender_flit[47:40] == 8'd0) zero_seen++;
            repeat (4) step();
        end
        chk("rnd_never_self", 64'(zero_seen), 64'd0);
        chk("rnd_pkt_cnt", txc_c, 16'd1000);

        // Reset in the middle of DATA abandons the packet.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("pre_rst_head", if_a.sender_flit, exp_tx(8, 0));
        step();
        chk("pre_rst_data", {if_a.sender_valid, if_a.sender_is_header, if_a.sender_flit},
            {1'b1, 1'b0, exp_tx(8, 1)});
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", if_a.sender_valid, 1'b0);
        chk("midrst_flit", if_a.sender_flit, 64'd0);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_counts", {txc_a, rxc_a, erc_a}, 48'd0);
        chk("midrst_ready", if_a.receive_ready, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("postrst_valid", if_a.sender_valid, 1'b0);
        chk("postrst_tx_cnt", txc_a, 16'd0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("postrst_seq0", if_a.sender_flit, exp_tx(0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/noc_traffic_node.md
NOC_TRAFFIC_NODE -- requirements
Module: noc_traffic_node

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- DATA_W, 64, flit width; minimum 48.
- ID_X_W, 4, X coordinate width.
- ID_Y_W, 4, Y coordinate width.
- X_ID, 0, own X coordinate.
- Y_ID, 0, own Y coordinate.
- PAYLOAD_LEN, 2, data flits per packet; legal range 1..15.
- NUM_PKTS, 4, packets per burst; 0 means unlimited until reset.
- DEST_MODE, 0, destination select: 0 = fixed DEST_X_ID/DEST_Y_ID, 1 = LFSR-random.
- DEST_X_ID, 1, fixed destination X.
- DEST_Y_ID, 0, fixed destination Y.
- LFSR_SEED, 16'hACE1, LFSR seed; must be nonzero.

REQ-002 SHALL have these ports (name, direction, width, meaning):
- noc_clk, in, 1, clock.
- noc_rst_n, in, 1, reset.
- send_start, in, 1, starts a burst when idle.
- receive_valid, in, 1, inbound flit valid.
- receive_ready, out, 1, inbound flit accepted.
- receive_flit, in, DATA_W, inbound flit.
- receive_is_header, in, 1, inbound head flag.
- receive_is_tail, in, 1, inbound tail flag.
- sender_valid, out, 1, outbound flit valid.
- sender_ready, in, 1, router can accept.
- sender_flit, out, DATA_W, outbound flit.
- sender_is_header, out, 1, outbound head flag.
- sender_is_tail, out, 1, outbound tail flag.
- tx_busy, out, 1, burst in progress.
- tx_pkt_cnt, out, 16, packets sent.
- rx_pkt_cnt, out, 16, good packets received.
- rx_err_cnt, out, 16, packet errors.

REQ-003 SHALL use one clock, noc_clk; reset noc_rst_n is asynchronous and active-low.

Function
REQ-004 SHALL format head flits as: [DATA_W-1:DATA_W-8]=8'hA5, then src X, src Y, dst X, dst Y, len[3:0]=PAYLOAD_LEN, seq[7:0]; remaining LSBs zero.
REQ-005 SHALL format tail flits identically to head flits except the marker is 8'h5A.
REQ-006 SHALL form data flit k (k = 0..PAYLOAD_LEN-1) as {src X, src Y, seq, k[3:0]}, zero-extended into the LSBs.
REQ-007 A flit SHALL transfer on a cycle where sender_valid and sender_ready are both 1; sender_valid, sender_flit and the flags SHALL be held stable until that transfer.
REQ-008 The TX FSM SHALL have states IDLE, HEAD, DATA, TAIL:
- IDLE to HEAD on send_start.
- HEAD to DATA on transfer.
- DATA stays in DATA until PAYLOAD_LEN data flits have transferred, then goes to TAIL.
- TAIL to HEAD on transfer if burst packets remain, else to IDLE.
REQ-009 sender_valid SHALL be 1 in HEAD, DATA and TAIL, and 0 in IDLE.
REQ-010 sender_is_header SHALL be 1 only in HEAD; sender_is_tail SHALL be 1 only in TAIL.
REQ-011 send_start SHALL be ignored outside IDLE.
REQ-012 seq SHALL increment (mod 256) after each tail transfer; tx_pkt_cnt SHALL increment on each tail transfer and saturate at 16'hFFFF.
REQ-013 In DEST_MODE 1, a 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per packet on entry to HEAD. dst X/Y SHALL be taken from lfsr[ID_X_W+ID_Y_W-1:0]. If that equals the own ID, dst X SHALL be incremented, wrapping modulo 2^ID_X_W.
REQ-014 tx_busy SHALL be 1 whenever the TX FSM is not in IDLE.
REQ-015 receive_ready SHALL be 1 in every cycle after reset.
REQ-016 The RX FSM SHALL have states R_HEAD, R_DATA, R_TAIL, with a data-flit counter, and SHALL latch src and seq from the head flit.
REQ-017 A packet error SHALL be counted once, after which the RX FSM returns to R_HEAD, for any of:
- head flit with the wrong marker or receive_is_header=0;
- dst not equal to own ID;
- len not equal to PAYLOAD_LEN;
- data flit not matching REQ-006;
- receive_is_header=1 seen in R_DATA or R_TAIL;
- tail flit fields not matching the latched head, or receive_is_tail=0.
REQ-018 A head flit that terminates a packet with an error (receive_is_header=1 in R_DATA/R_TAIL) SHALL itself be processed as a new header in that same cycle.
REQ-019 A valid tail SHALL increment rx_pkt_cnt; rx_pkt_cnt and rx_err_cnt SHALL saturate at 16'hFFFF.
REQ-020 In simulation, the block SHALL print one line per packet sent and one line per packet received (source, destination, seq).

Reset
REQ-021 On noc_rst_n low, the block SHALL immediately enter TX IDLE and RX R_HEAD, and SHALL clear seq and all counters to 0. sender_valid, sender_flit, sender_is_header and sender_is_tail SHALL be 0, receive_ready SHALL be 0 while reset is asserted, and the LFSR SHALL load LFSR_SEED.
REQ-022 A reset asserted in the middle of a packet SHALL abandon that packet, and no counter SHALL be incremented for it.

Verification
REQ-023 Defaults, send_start pulse, sender_ready=1 -> burst of 16 flits: 4 packets x (head, 2 data, tail) on consecutive cycles; tx_pkt_cnt=4; tx_busy falls after the final tail.
REQ-024 sender_ready toggling 1/0 every cycle -> each flit's value and flags stay stable until accepted; flit order is identical to REQ-023.
REQ-025 Loopback of the sender outputs into the receive inputs with X_ID=DEST_X_ID=1 -> rx_pkt_cnt=4 and rx_err_cnt=0.
REQ-026 Inject one data flit with k corrupted, then a good packet -> rx_err_cnt=1 and rx_pkt_cnt=1.
REQ-027 Inject a head, a data flit, then a new head in place of the second data flit -> rx_err_cnt=1, and the second packet is received correctly.
REQ-028 DEST_MODE=1 with X_ID=Y_ID=0 over 1000 packets -> the destination is never (0,0); reset during DATA -> sender_valid=0 in the same cycle and tx_pkt_cnt=0.
